// File: rtl/byte_striping_pkg.sv
// Definitions shared by the 4-lane byte striper (Tx) and unstriper (Rx):
// lane count, default byte width, lane index type and the emit FSM encoding.
package byte_striping_pkg;

    localparam int NUM_LANES  = 4;
    localparam int DEF_DATA_W = 8;
    localparam int LANE_IDX_W = 2;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    localparam lane_idx_t LAST_LANE = lane_idx_t'(NUM_LANES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/unstripe_group_fifo.sv
// Synchronous FIFO holding whole lane groups (one entry = all lanes of a group).
// Exposes the head entry and the entry behind it so the reader can chain groups without a bubble.
module unstripe_group_fifo #(
    parameter int ENTRY_W = 32,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic [ENTRY_W-1:0] head_next,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_push   = push & !full;
    assign do_pop    = pop & !empty;
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + PTR_W'(1)];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/byte_unstriping_rx.sv
// Rx byte unstriper: buffers 4-lane groups and re-serialises them lane 0..3 onto one byte stream.
// Define BYTE_UNSTRIPE_CNT_EN to add the byte_cnt / drop_cnt statistics outputs.
module byte_unstriping_rx
    import byte_striping_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int GRP_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] lane_valid,
    input  logic [DATA_W-1:0]    data_in0,
    input  logic [DATA_W-1:0]    data_in1,
    input  logic [DATA_W-1:0]    data_in2,
    input  logic [DATA_W-1:0]    data_in3,
    output logic                 in_ready,
    output logic [DATA_W-1:0]    data_out,
    output logic                 valid_out,
    input  logic                 out_ready,
    output logic                 skew_err,
    output fsm_state_t           fsm_state
`ifdef BYTE_UNSTRIPE_CNT_EN
    ,
    output logic [15:0]          byte_cnt,
    output logic [7:0]           drop_cnt
`endif
);

    localparam int ENTRY_W = NUM_LANES * DATA_W;
    localparam int CNT_W   = $clog2(GRP_DEPTH) + 1;

    // Handshake: a byte transfers on any rising edge where valid_out & out_ready;
    // a group transfers where lane_valid is all ones & in_ready.

    fsm_state_t         state;
    fsm_state_t         state_nxt;
    lane_idx_t          lane_idx;
    lane_idx_t          lane_nxt;
    logic               valid_nxt;
    logic [DATA_W-1:0]  data_nxt;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] head_next;
    logic [ENTRY_W-1:0] wr_entry;
    logic [CNT_W-1:0]   count;

    logic               full_group;
    logic               partial;
    logic               hs;
    logic               more;

    function automatic logic [DATA_W-1:0] pick(input logic [ENTRY_W-1:0] entry, input lane_idx_t idx);
        return entry[int'(idx)*DATA_W +: DATA_W];
    endfunction

    assign full_group = (lane_valid == {NUM_LANES{1'b1}});
    assign partial    = (lane_valid != '0) && !full_group;
    assign in_ready   = !full;
    assign push       = full_group & in_ready;
    assign wr_entry   = {data_in3, data_in2, data_in1, data_in0};
    assign hs         = valid_out & out_ready;
    assign more       = (count > CNT_W'(1));
    assign fsm_state  = state;

    unstripe_group_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (GRP_DEPTH),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .wr_data   (wr_entry),
        .pop       (pop),
        .head      (head),
        .head_next (head_next),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lane_idx  <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            skew_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            lane_idx  <= lane_nxt;
            valid_out <= valid_nxt;
            data_out  <= data_nxt;
            if (partial) begin
                skew_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!empty) state_nxt = EMIT;
            EMIT: if (hs && lane_idx == LAST_LANE && !more) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The byte following the last lane comes from head_next, since the pop has not landed yet.
    always_comb begin
        valid_nxt = valid_out;
        data_nxt  = data_out;
        lane_nxt  = lane_idx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (!empty) begin
                    valid_nxt = 1'b1;
                    lane_nxt  = '0;
                    data_nxt  = pick(head, '0);
                end
            end
            EMIT: begin
                if (hs) begin
                    if (lane_idx == LAST_LANE) begin
                        pop      = 1'b1;
                        lane_nxt = '0;
                        if (more) begin
                            valid_nxt = 1'b1;
                            data_nxt  = pick(head_next, '0);
                        end else begin
                            valid_nxt = 1'b0;
                        end
                    end else begin
                        lane_nxt = lane_idx + lane_idx_t'(1);
                        data_nxt = pick(head, lane_idx + lane_idx_t'(1));
                    end
                end
            end
            default: begin
                valid_nxt = 1'b0;
            end
        endcase
    end

`ifdef BYTE_UNSTRIPE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (hs && byte_cnt != 16'hFFFF) begin
                byte_cnt <= byte_cnt + 16'd1;
            end
            if (partial && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_byte_unstriping_rx.sv
// Directed bench for byte_unstriping_rx: reset, latency, back-to-back, backpressure, skew, mid-stream reset.
// Define BYTE_UNSTRIPE_CNT_EN to also exercise the statistics counters.
module tb_byte_unstriping_rx;
    import byte_striping_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] lane_valid = 4'h0;
    logic [7:0] data_in0 = 8'h00;
    logic [7:0] data_in1 = 8'h00;
    logic [7:0] data_in2 = 8'h00;
    logic [7:0] data_in3 = 8'h00;
    logic       in_ready;
    logic [7:0] data_out;
    logic       valid_out;
    logic       out_ready = 1'b1;
    logic       skew_err;
    fsm_state_t fsm_state;
`ifdef BYTE_UNSTRIPE_CNT_EN
    logic [15:0] byte_cnt;
    logic [7:0]  drop_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    byte_unstriping_rx #(.DATA_W(8), .GRP_DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .lane_valid (lane_valid),
        .data_in0   (data_in0),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .data_in3   (data_in3),
        .in_ready   (in_ready),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .out_ready  (out_ready),
        .skew_err   (skew_err),
        .fsm_state  (fsm_state)
`ifdef BYTE_UNSTRIPE_CNT_EN
        ,
        .byte_cnt   (byte_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] lv, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        lane_valid = lv;
        data_in0   = b0;
        data_in1   = b1;
        data_in2   = b2;
        data_in3   = b3;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b want 0", valid_out);
        end
        vectors++;
        if (data_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 00", data_out);
        end
        vectors++;
        if (skew_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_skew: got %b want 0", skew_err);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        vectors++;
        if (fsm_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d want IDLE", fsm_state);
        end
    endtask

    task automatic test_single_group();
        drive(4'hF, 8'h01, 8'h02, 8'h03, 8'h04);
        tick();
        lane_valid = 4'h0;
        vectors++;
        if (valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL single_latency: valid got %b want 0 at accept edge", valid_out);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            vectors++;
            if (valid_out !== 1'b1 || data_out !== 8'(k)) begin
                miscompares++;
                $display("FAIL single_byte%0d: got v=%b d=%h want v=1 d=%h", k, valid_out, data_out, 8'(k));
            end
        end
        tick();
        vectors++;
        if (valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL single_after: valid got %b want 0", valid_out);
        end
    endtask

    task automatic test_back_to_back();
        drive(4'hF, 8'h01, 8'h02, 8'h03, 8'h04);
        tick();
        lane_valid = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) drive(4'hF, 8'h05, 8'h06, 8'h07, 8'h08);
            tick();
            lane_valid = 4'h0;
            vectors++;
            if (valid_out !== 1'b1 || data_out !== 8'(k)) begin
                miscompares++;
                $display("FAIL b2b_byte%0d: got v=%b d=%h want v=1 d=%h", k, valid_out, data_out, 8'(k));
            end
        end
        tick();
        vectors++;
        if (valid_out !== 1'b0 || skew_err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: got v=%b skew=%b want v=0 skew=0", valid_out, skew_err);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(4'hF, 8'h01, 8'h02, 8'h03, 8'h04);
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_one_group_ready: got %b want 1", in_ready);
        end
        drive(4'hF, 8'h05, 8'h06, 8'h07, 8'h08);
        tick();
        lane_valid = 4'h0;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full_ready: got %b want 0", in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (valid_out !== 1'b1 || data_out !== 8'h01 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b want v=1 d=01 rdy=0",
                         i, valid_out, data_out, in_ready);
            end
        end
        out_ready = 1'b1;
        for (int k = 2; k <= 8; k++) begin
            tick();
            vectors++;
            if (valid_out !== 1'b1 || data_out !== 8'(k)) begin
                miscompares++;
                $display("FAIL bp_resume%0d: got v=%b d=%h want v=1 d=%h", k, valid_out, data_out, 8'(k));
            end
        end
        tick();
        vectors++;
        if (valid_out !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_end: got v=%b rdy=%b want v=0 rdy=1", valid_out, in_ready);
        end
    endtask

    task automatic test_skew();
        drive(4'b0111, 8'h0A, 8'h0B, 8'h0C, 8'h00);
        tick();
        lane_valid = 4'h0;
        vectors++;
        if (skew_err !== 1'b1 || valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL skew_set: got skew=%b v=%b want skew=1 v=0", skew_err, valid_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (skew_err !== 1'b1 || valid_out !== 1'b0) begin
                miscompares++;
                $display("FAIL skew_hold%0d: got skew=%b v=%b want skew=1 v=0", i, skew_err, valid_out);
            end
        end
        drive(4'hF, 8'h0D, 8'h0E, 8'h0F, 8'h10);
        tick();
        lane_valid = 4'h0;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (valid_out !== 1'b1 || data_out !== 8'(8'h0D + k)) begin
                miscompares++;
                $display("FAIL skew_next%0d: got v=%b d=%h want v=1 d=%h", k, valid_out, data_out, 8'(8'h0D + k));
            end
        end
        tick();
        vectors++;
        if (valid_out !== 1'b0 || skew_err !== 1'b1) begin
            miscompares++;
            $display("FAIL skew_end: got v=%b skew=%b want v=0 skew=1", valid_out, skew_err);
        end
    endtask

    task automatic test_reset_mid();
        drive(4'hF, 8'h01, 8'h02, 8'h03, 8'h04);
        tick();
        lane_valid = 4'h0;
        tick();
        tick();
        vectors++;
        if (valid_out !== 1'b1 || data_out !== 8'h02) begin
            miscompares++;
            $display("FAIL rmid_pre: got v=%b d=%h want v=1 d=02", valid_out, data_out);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (valid_out !== 1'b0 || in_ready !== 1'b1 || skew_err !== 1'b0 || data_out !== 8'h00) begin
            miscompares++;
            $display("FAIL rmid_reset: got v=%b rdy=%b skew=%b d=%h want v=0 rdy=1 skew=0 d=00",
                     valid_out, in_ready, skew_err, data_out);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (valid_out !== 1'b0) begin
                miscompares++;
                $display("FAIL rmid_quiet%0d: got v=%b d=%h want v=0", i, valid_out, data_out);
            end
        end
    endtask

`ifdef BYTE_UNSTRIPE_CNT_EN
    task automatic test_counters();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (byte_cnt !== 16'd0 || drop_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL cnt_reset: got bytes=%0d drops=%0d want 0 0", byte_cnt, drop_cnt);
        end
        for (int g = 0; g < 3; g++) begin
            drive(4'hF, 8'(4*g+1), 8'(4*g+2), 8'(4*g+3), 8'(4*g+4));
            tick();
            lane_valid = 4'h0;
            tick();
            tick();
            tick();
        end
        drive(4'b0011, 8'h20, 8'h21, 8'h00, 8'h00);
        tick();
        lane_valid = 4'h0;
        for (int i = 0; i < 10; i++) tick();
        vectors++;
        if (byte_cnt !== 16'd12 || drop_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL cnt_totals: got bytes=%0d drops=%0d want 12 1", byte_cnt, drop_cnt);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_group();
        test_back_to_back();
        test_backpressure();
        test_skew();
        test_reset_mid();
`ifdef BYTE_UNSTRIPE_CNT_EN
        test_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/byte_unstriping_rx.md
Name: byte_unstriping_rx

Overview:
- Receive-side counterpart of the 4-lane byte striper.
- Accepts one byte per lane per group (lane0..lane3, all lanes in the same cycle) and re-serialises them into a single 8-bit stream in lane order 0,1,2,3.
- Buffers whole groups to absorb downstream backpressure.
- Flags lane misalignment, i.e. a partial group.

Parameters:
- DATA_W, 8, width of each lane byte and of the output byte.
- GRP_DEPTH, 2, number of 4-byte groups buffered (power of 2, min 2).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- lane_valid  input  4  per-lane valid; bit i qualifies data_in_i.
- data_in0  input  DATA_W  lane 0 byte (first in stream order).
- data_in1  input  DATA_W  lane 1 byte.
- data_in2  input  DATA_W  lane 2 byte.
- data_in3  input  DATA_W  lane 3 byte (last in stream order).
- in_ready  output  1  group buffer can accept a group this cycle.
- data_out  output  DATA_W  reassembled byte.
- valid_out  output  1  data_out valid.
- out_ready  input  1  downstream accepts data_out when valid_out & out_ready.
- skew_err  output  1  sticky; set on a partial group.

Behaviour:
- Reset (sync, active-high, sampled at posedge clk) clears:
  - group buffer, pointers, lane index, state;
  - outputs: data_out=0, valid_out=0, skew_err=0, in_ready=1 (the cycle after reset asserts).
- Reset mid-operation discards all buffered and partially emitted groups; no byte is emitted after reset.
- Group accept: lane_valid==4'hF and in_ready at posedge clk; all four bytes are written as one entry.
- in_ready = !full, from registered count only (no combinational path from out_ready). When full, a pop in the same cycle does not open a slot until the next cycle.
- Partial group: lane_valid not 0 and not F.
  - Group is dropped, nothing written.
  - skew_err set next cycle and held until reset.
- lane_valid==0: no action.
- Output FSM:
  - IDLE: valid_out=0. Go to EMIT when the buffer is non-empty; lane_idx=0.
  - EMIT: valid_out=1, data_out=byte[lane_idx] of head entry. On valid_out&out_ready, lane_idx increments.
  - At lane_idx==3 with a handshake, the head entry is popped. Stay in EMIT at lane 0 if another entry is present, else go to IDLE.
  - data_out/valid_out are registered and hold stable while valid_out&!out_ready.
- Latency: group accepted at edge N into an empty block -> lane0 byte valid after edge N+1.
- Throughput: 1 byte/cycle with out_ready=1. Back-to-back emission across groups with no bubble.
- Sustained input rate: 1 group per 4 cycles. Faster input fills the buffer and deasserts in_ready.
- Simultaneous accept and final pop when not full: both occur; count unchanged.
- Pointer wrap: modulo GRP_DEPTH. Count width clog2(GRP_DEPTH)+1.

Optional Feature:
- Macro BYTE_UNSTRIPE_CNT_EN.
- Defined:
  - extra output byte_cnt[15:0], reset 0, increments on each valid_out&out_ready handshake, saturates at 16'hFFFF.
  - extra output drop_cnt[7:0], counts partial groups, saturating.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package byte_striping_pkg:
  - NUM_LANES=4;
  - default DATA_W=8;
  - FSM state encoding IDLE/EMIT;
  - lane index width 2.
- Shared with the Tx striper.
- One sub-module: unstripe_group_fifo, a synchronous FIFO of 4*DATA_W-wide entries, depth GRP_DEPTH, exposing full/empty/push/pop/head.

Test Plan:
- Reset then one group 01,02,03,04 with out_ready=1 -> data_out 01,02,03,04 on four consecutive cycles starting edge N+1; valid_out low afterwards.
- Groups 01..04 and 05..08 every 4 cycles (mirroring Tx stimulus 01..12 hex) -> continuous stream 01..08, no bubbles, skew_err=0.
- out_ready=0 for 10 cycles while feeding groups -> in_ready falls after GRP_DEPTH groups; data_out holds 01; on release the stream resumes in order with no loss or duplication.
- lane_valid=4'b0111 with 0A,0B,0C -> nothing emitted, skew_err=1 next cycle and stays 1; a following full group 0D,0E,0F,10 is still emitted correctly.
- reset asserted after byte 02 of group 01..04 -> valid_out=0 next cycle, bytes 03/04 never appear, in_ready=1.
- With BYTE_UNSTRIPE_CNT_EN: 3 full groups + 1 partial -> byte_cnt=12, drop_cnt=1.
